// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared architecture constants for the fetch stage (halt items under FETCH_HALT_EN)
package fetch_unit_pkg;

    localparam int ADDRESS_SIZE     = 12;
    localparam int INSTRUCTION_SIZE = 16;

    localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTRUCTION = 16'h0000;

`ifdef FETCH_HALT_EN
    localparam int OPCODE_HI   = 15;
    localparam int OPCODE_LO   = 12;
    localparam int OPCODE_SIZE = OPCODE_HI - OPCODE_LO + 1;

    localparam logic [OPCODE_SIZE-1:0] HALT_OPCODE = 4'hF;

    localparam logic [0:0] FETCH_RUN    = 1'b0;
    localparam logic [0:0] FETCH_HALTED = 1'b1;

    function automatic logic is_halt(input logic [INSTRUCTION_SIZE-1:0] word);
        return word[OPCODE_HI:OPCODE_LO] == HALT_OPCODE;
    endfunction
`endif

endpackage

// File: rtl/fetch_unit_pc_counter_reg.sv
// rtl/fetch_unit_pc_counter_reg.sv - program counter register with load, wrapping increment and hold
module fetch_unit_pc_counter_reg
    import fetch_unit_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [ADDRESS_SIZE-1:0] load_value,
    input  logic                    advance,
    output logic [ADDRESS_SIZE-1:0] value
);

    localparam logic [ADDRESS_SIZE-1:0] STEP = ADDRESS_SIZE'(1);

    // Increment wraps naturally at the register width; no overflow indication.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (advance) begin
            value <= value + STEP;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; FETCH_HALT_EN adds the HALTED state
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        jump,
    input  logic [ADDRESS_SIZE-1:0]     jump_address,
    output logic [ADDRESS_SIZE-1:0]     fetch_address,
    input  logic [INSTRUCTION_SIZE-1:0] fetch_data,
    output logic [ADDRESS_SIZE-1:0]     pc,
    output logic [INSTRUCTION_SIZE-1:0] instruction,
    output logic                        halted
);

    logic [ADDRESS_SIZE-1:0] pc_counter;
    logic                    advance;

`ifdef FETCH_HALT_EN
    logic [0:0] state;

    assign halted = (state == FETCH_HALTED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH_RUN;
        end else if (jump) begin
            state <= FETCH_RUN;
        end else if (advance && is_halt(fetch_data)) begin
            state <= FETCH_HALTED;
        end
    end
`else
    assign halted = 1'b0;
`endif

    // Jump outranks halt and stall; only a clean RUN cycle moves the counter.
    assign advance       = !jump && !halted && !stall;
    assign fetch_address = pc_counter;

    fetch_unit_pc_counter_reg u_pc_counter_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (jump),
        .load_value (jump_address),
        .advance    (advance),
        .value      (pc_counter)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            instruction <= NOP_INSTRUCTION;
        end else if (jump || halted) begin
            // Redirect bubble and halted idle both present a NOP at address 0.
            pc          <= '0;
            instruction <= NOP_INSTRUCTION;
        end else if (!stall) begin
            pc          <= pc_counter;
            instruction <= fetch_data;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clock  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; fetch_unit reinitialises immediately on falling edge.
REQ-003 stall  input  1  hazard hold from read_unit control; 1 = freeze fetch stage.
REQ-004 jump  input  1  taken-jump redirect from execute stage; 1 = load jump_address.
REQ-005 jump_address  input  ADDRESS_SIZE  redirect target PC.
REQ-006 fetch_address  output  ADDRESS_SIZE  instruction memory address; combinationally equals program counter register.
REQ-007 fetch_data  input  INSTRUCTION_SIZE  instruction memory word at fetch_address, combinational read.
REQ-008 pc  output  ADDRESS_SIZE  registered address of the instruction presented to read_unit.
REQ-009 instruction  output  INSTRUCTION_SIZE  registered instruction presented to read_unit.
REQ-010 halted  output  1  1 = stage is in HALTED state.

Function
REQ-011 Internal program counter pc_counter (ADDRESS_SIZE) SHALL drive fetch_address.
REQ-012 Priority per edge SHALL be: reset > jump > HALTED > stall > advance.
REQ-013 Advance: pc <= pc_counter; instruction <= fetch_data; pc_counter <= pc_counter + 1.
REQ-014 Increment SHALL wrap modulo 2^ADDRESS_SIZE (all-ones -> 0), no flag.
REQ-015 Stall (jump=0): pc, instruction, pc_counter, state SHALL hold unchanged.
REQ-016 Jump: pc_counter <= jump_address; instruction <= NOP_INSTRUCTION; pc <= 0; state <= RUN; applies even when stall=1 or state is HALTED.
REQ-017 Instruction at jump_address SHALL appear on instruction exactly one edge after the redirect edge (one-cycle bubble).
REQ-018 Fetch latency: fetch_data sampled at edge N appears on instruction/pc after edge N, held until next advance.
REQ-019 State machine: RUN, HALTED (HALTED only with HALT_EN); reset -> RUN.
REQ-020 RUN -> HALTED on an advance edge where fetch_data opcode field equals HALT; HALT word itself is registered to instruction on that edge.
REQ-021 HALTED: pc_counter frozen; instruction <= NOP_INSTRUCTION, pc <= 0 each edge; halted = 1; exit only via jump or reset.
REQ-022 HALT fetched while stall=1 SHALL NOT transition; transition occurs on the advance edge after stall drops.

Reset
REQ-023 On reset low: pc_counter = 0, pc = 0, instruction = NOP_INSTRUCTION, state = RUN, halted = 0.
REQ-024 Reset asserted mid-stall, mid-redirect or in HALTED SHALL override all; first advance after release fetches address 0.

Configuration
REQ-025 Macro FETCH_HALT_EN: defined -> HALTED state and REQ-020..REQ-022 implemented.
REQ-026 FETCH_HALT_EN undefined -> HALT opcode treated as ordinary instruction, halted tied to 0, single-state RUN.

Structure
REQ-027 NOP_INSTRUCTION, HALT opcode value, fetch state encodings SHALL be added to architecture.vh; ADDRESS_SIZE, INSTRUCTION_SIZE, OPCODE_SELECT reused from it.
REQ-028 One sub-module pc_counter_reg (load/increment/hold register with async reset) is natural; remaining logic inline.

Verification
REQ-029 Reset release, memory word at addr k = 0x1000+k, stall=0 -> instruction 0x1000,0x1001,0x1002 on successive edges, pc 0,1,2.
REQ-030 stall=1 for 3 cycles at pc=5 -> pc=5, instruction, fetch_address=6 unchanged for 3 edges; resume with addr 6.
REQ-031 jump=1, jump_address=0x040 with stall=1 -> next edge instruction=NOP_INSTRUCTION, fetch_address=0x040; following edge pc=0x040.
REQ-032 pc_counter = all-ones, advance -> fetch_address wraps to 0, pc = all-ones.
REQ-033 FETCH_HALT_EN: HALT at addr 3 -> pc=3 shows HALT, then halted=1, NOP output indefinitely; jump to 0x010 -> RUN, halted=0.
REQ-034 Reset asserted while HALTED and while stall=1 -> all outputs at reset values immediately, no clock edge required.
